// File: rtl/tube_pkg.sv
// Shared constants for the tube scan driver: segment codes and bit positions.
package tube_pkg;

  // Segment codes, [6:0] = g..a active-high, [7] = dp active-low (1 = off).
  localparam logic [7:0] SEG_0     = 8'b1011_1111;
  localparam logic [7:0] SEG_1     = 8'b1000_0110;
  localparam logic [7:0] SEG_2     = 8'b1101_1011;
  localparam logic [7:0] SEG_3     = 8'b1100_1111;
  localparam logic [7:0] SEG_4     = 8'b1110_0110;
  localparam logic [7:0] SEG_5     = 8'b1110_1101;
  localparam logic [7:0] SEG_6     = 8'b1111_1101;
  localparam logic [7:0] SEG_7     = 8'b1000_0111;
  localparam logic [7:0] SEG_8     = 8'b1111_1111;
  localparam logic [7:0] SEG_9     = 8'b1110_1111;
  localparam logic [7:0] SEG_BLANK = 8'b1000_0000;

  localparam int unsigned DP_BIT = 7;

endpackage

// File: rtl/tube_seg_decode.sv
// Combinational BCD + decimal point + blank to 8-bit tube segment code.
module tube_seg_decode
  import tube_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       dp_i,
  input  logic       blank_i,
  output logic [7:0] seg_o
);

  // Blank overrides everything, including the decimal point.
  always_comb begin
    seg_o = SEG_BLANK;
    if (!blank_i) begin
      case (bcd_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_BLANK;
      endcase
      if (dp_i) seg_o[DP_BIT] = 1'b0;
    end
  end

endmodule

// File: rtl/tube_scan_driver.sv
// Multiplexed 7-segment scan driver: double-buffered digits, leading-zero
// blanking, per-digit blink and a guard interval against ghosting.
module tube_scan_driver
  import tube_pkg::*;
#(
  parameter int unsigned DIGITS       = 8,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned GUARD        = 16,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   digits_bcd,
  input  logic [DIGITS-1:0]     dp_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_en,
  input  logic                  load,
  output logic [7:0]            tube_value,
  output logic [DIGITS-1:0]     tube_select,
  output logic                  frame_done
);

  localparam int unsigned PW = $clog2(SCAN_DIV);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [PW-1:0]          presc_q, presc_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [FW-1:0]          frame_cnt_q, frame_cnt_d;
  logic                   blink_on_q, blink_on_d;
  logic                   pending_q, pending_d;

  logic [4*DIGITS-1:0]    stg_digits_q, stg_digits_d;
  logic [DIGITS-1:0]      stg_dp_q, stg_dp_d;
  logic [DIGITS-1:0]      stg_blink_q, stg_blink_d;
  logic                   stg_lz_q, stg_lz_d;

  logic [4*DIGITS-1:0]    act_digits_q, act_digits_d;
  logic [DIGITS-1:0]      act_dp_q, act_dp_d;
  logic [DIGITS-1:0]      act_blink_q, act_blink_d;
  logic                   act_lz_q, act_lz_d;

  logic [7:0]             tube_value_q, tube_value_d;
  logic [DIGITS-1:0]      tube_select_q, tube_select_d;
  logic                   frame_done_q, frame_done_d;

  logic                   slot_wrap, frame_wrap;
  logic [DIGITS-1:0]      lz_blank;
  logic                   lz_run;
  logic [3:0]             cur_bcd;
  logic                   cur_dp, cur_blank;
  logic [7:0]             cur_seg;

  // Scan counters: prescaler within a slot, digit index, blink frame counter.
  always_comb begin
    slot_wrap   = (presc_q == PW'(SCAN_DIV - 1));
    frame_wrap  = slot_wrap && (idx_q == IW'(DIGITS - 1));
    presc_d     = presc_q + PW'(1);
    idx_d       = idx_q;
    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    if (slot_wrap) begin
      presc_d = '0;
      idx_d   = frame_wrap ? '0 : idx_q + IW'(1);
    end
    if (frame_wrap) begin
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_on_d  = ~blink_on_q;
      end else begin
        frame_cnt_d = frame_cnt_q + FW'(1);
      end
    end
  end

  // Double buffer: loads land in staging, commit to active only on a frame
  // boundary so a frame never mixes old and new digits.
  always_comb begin
    stg_digits_d = stg_digits_q;
    stg_dp_d     = stg_dp_q;
    stg_blink_d  = stg_blink_q;
    stg_lz_d     = stg_lz_q;
    act_digits_d = act_digits_q;
    act_dp_d     = act_dp_q;
    act_blink_d  = act_blink_q;
    act_lz_d     = act_lz_q;
    pending_d    = pending_q;
    if (load) begin
      stg_digits_d = digits_bcd;
      stg_dp_d     = dp_mask;
      stg_blink_d  = blink_mask;
      stg_lz_d     = lz_en;
      pending_d    = 1'b1;
    end
    if (frame_wrap) begin
      if (load) begin
        // Boundary-coincident load bypasses staging straight into the new frame.
        act_digits_d = digits_bcd;
        act_dp_d     = dp_mask;
        act_blink_d  = blink_mask;
        act_lz_d     = lz_en;
        pending_d    = 1'b0;
      end else if (pending_q) begin
        act_digits_d = stg_digits_q;
        act_dp_d     = stg_dp_q;
        act_blink_d  = stg_blink_q;
        act_lz_d     = stg_lz_q;
        pending_d    = 1'b0;
      end
    end
  end

  // Leading-zero blanking: a digit is blank while it and all higher digits are
  // zero without a decimal point. Digit 0 always shows.
  always_comb begin
    lz_blank = '0;
    lz_run   = act_lz_d;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      lz_run      = lz_run && (act_digits_d[4*i +: 4] == 4'd0) && !act_dp_d[i];
      lz_blank[i] = lz_run;
    end
  end

  // Outputs are computed from next-state so the registered pins line up with
  // the counters they describe.
  always_comb begin
    cur_bcd       = act_digits_d[{idx_d, 2'b00} +: 4];
    cur_dp        = act_dp_d[idx_d];
    cur_blank     = lz_blank[idx_d] | (~blink_on_d & act_blink_d[idx_d]);
    tube_select_d = '1;
    if (32'(presc_d) >= GUARD) tube_select_d[idx_d] = 1'b0;
    tube_value_d  = cur_seg;
    frame_done_d  = frame_wrap;
  end

  tube_seg_decode u_seg_decode (
    .bcd_i   (cur_bcd),
    .dp_i    (cur_dp),
    .blank_i (cur_blank),
    .seg_o   (cur_seg)
  );

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q       <= '0;
      idx_q         <= '0;
      frame_cnt_q   <= '0;
      blink_on_q    <= 1'b1;
      pending_q     <= 1'b0;
      stg_digits_q  <= '0;
      stg_dp_q      <= '0;
      stg_blink_q   <= '0;
      stg_lz_q      <= 1'b0;
      act_digits_q  <= '0;
      act_dp_q      <= '0;
      act_blink_q   <= '0;
      act_lz_q      <= 1'b0;
      tube_value_q  <= SEG_BLANK;
      tube_select_q <= '1;
      frame_done_q  <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      idx_q         <= idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_on_q    <= blink_on_d;
      pending_q     <= pending_d;
      stg_digits_q  <= stg_digits_d;
      stg_dp_q      <= stg_dp_d;
      stg_blink_q   <= stg_blink_d;
      stg_lz_q      <= stg_lz_d;
      act_digits_q  <= act_digits_d;
      act_dp_q      <= act_dp_d;
      act_blink_q   <= act_blink_d;
      act_lz_q      <= act_lz_d;
      tube_value_q  <= tube_value_d;
      tube_select_q <= tube_select_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign tube_value  = tube_value_q;
  assign tube_select = tube_select_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_tube_scan_driver.sv
// Self-checking bench for tube_scan_driver with a cycle-count based reference model.
module tb_tube_scan_driver;

  localparam int unsigned D     = 4;
  localparam int unsigned SD    = 4;
  localparam int unsigned G     = 1;
  localparam int unsigned BF    = 2;
  localparam int unsigned FRAME = D * SD;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   digits_bcd;
  logic [3:0]    dp_mask;
  logic [3:0]    blink_mask;
  logic          lz_en;
  logic          load;
  logic [7:0]    tube_value;
  logic [3:0]    tube_select;
  logic          frame_done;

  int errors = 0;
  int checks = 0;

  // Reference model state: cycles since reset plus staging/active copies.
  int unsigned t;
  logic [15:0] stg_dig, act_dig;
  logic [3:0]  stg_dp, act_dp, stg_bl, act_bl;
  logic        stg_lz, act_lz, pend;
  logic [7:0]  seg_tab [16];

  tube_scan_driver #(
    .DIGITS       (D),
    .SCAN_DIV     (SD),
    .GUARD        (G),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .digits_bcd  (digits_bcd),
    .dp_mask     (dp_mask),
    .blink_mask  (blink_mask),
    .lz_en       (lz_en),
    .load        (load),
    .tube_value  (tube_value),
    .tube_select (tube_select),
    .frame_done  (frame_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    t = 0;
    stg_dig = '0; act_dig = '0;
    stg_dp  = '0; act_dp  = '0;
    stg_bl  = '0; act_bl  = '0;
    stg_lz  = 1'b0; act_lz = 1'b0;
    pend    = 1'b0;
  endtask

  task automatic model_edge();
    bit bnd;
    bnd = ((t + 1) % FRAME) == 0;
    if (load) begin
      stg_dig = digits_bcd; stg_dp = dp_mask; stg_bl = blink_mask; stg_lz = lz_en;
      if (bnd) begin
        act_dig = digits_bcd; act_dp = dp_mask; act_bl = blink_mask; act_lz = lz_en;
        pend = 1'b0;
      end else begin
        pend = 1'b1;
      end
    end else if (bnd && pend) begin
      act_dig = stg_dig; act_dp = stg_dp; act_bl = stg_bl; act_lz = stg_lz;
      pend = 1'b0;
    end
    t++;
  endtask

  function automatic logic [7:0] exp_value(input int unsigned idx, input int unsigned frame);
    logic [7:0] v;
    bit blank;
    blank = 1'b0;
    if (act_lz && idx >= 1) begin
      blank = 1'b1;
      for (int j = idx; j < D; j++)
        if (act_dig[4*j +: 4] != 4'd0 || act_dp[j]) blank = 1'b0;
    end
    if (act_bl[idx] && ((frame / BF) % 2 == 1)) blank = 1'b1;
    if (blank) begin
      v = 8'h80;
    end else begin
      v = seg_tab[act_dig[4*idx +: 4]];
      if (act_dp[idx]) v[7] = 1'b0;
    end
    return v;
  endfunction

  task automatic check_all();
    logic [3:0] esel;
    logic [7:0] eval;
    logic       efd;
    int unsigned idx;
    if (t == 0) begin
      esel = 4'hF; eval = 8'h80; efd = 1'b0;
    end else begin
      idx  = (t / SD) % D;
      efd  = (t % FRAME) == 0;
      esel = ((t % SD) < G) ? 4'hF : ~(4'b0001 << idx);
      eval = exp_value(idx, t / FRAME);
    end
    checks++;
    assert (tube_select === esel) else begin
      errors++; $error("FAIL select t=%0d got %b exp %b", t, tube_select, esel);
    end
    checks++;
    assert (tube_value === eval) else begin
      errors++; $error("FAIL value t=%0d got %b exp %b", t, tube_value, eval);
    end
    checks++;
    assert (frame_done === efd) else begin
      errors++; $error("FAIL frame_done t=%0d got %b exp %b", t, frame_done, efd);
    end
  endtask

  task automatic cycle(input logic ld);
    load = ld;
    @(posedge clk);
    model_edge();
    #1;
    load = 1'b0;
    check_all();
  endtask

  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      cycle(1'b0);
      n++;
    end while (frame_done !== 1'b1 && n < 40);
    checks++;
    assert (frame_done === 1'b1) else begin
      errors++; $error("FAIL wait_frame got %b exp 1", frame_done);
    end
  endtask

  // Called on a frame_done cycle; checks each slot just after its guard
  // cycle against spec-derived constants (digit i at vals[8i +: 8]).
  task automatic check_frame(input string tag, input logic [31:0] vals);
    logic [3:0] esel;
    for (int s = 0; s < 4; s++) begin
      cycle(1'b0);
      esel = ~(4'b0001 << s);
      checks++;
      assert (tube_select === esel) else begin
        errors++; $error("FAIL %s sel slot %0d got %b exp %b", tag, s, tube_select, esel);
      end
      checks++;
      assert (tube_value === vals[8*s +: 8]) else begin
        errors++;
        $error("FAIL %s val slot %0d got %b exp %b", tag, s, tube_value, vals[8*s +: 8]);
      end
      cycle(1'b0);
      cycle(1'b0);
      if (s < 3) cycle(1'b0);
    end
  endtask

  task automatic set_in(input logic [15:0] dig, input logic [3:0] dp, input logic [3:0] bl,
                        input logic lz);
    digits_bcd = dig; dp_mask = dp; blink_mask = bl; lz_en = lz;
  endtask

  initial begin
    seg_tab = '{8'hBF, 8'h86, 8'hDB, 8'hCF, 8'hE6, 8'hED, 8'hFD, 8'h87,
                8'hFF, 8'hEF, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80, 8'h80};
    rst_n = 1'b0;
    load  = 1'b0;
    set_in(16'h0000, 4'h0, 4'h0, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // 1234, no blanking.
    set_in(16'h1234, 4'h0, 4'h0, 1'b0);
    cycle(1'b1);
    wait_frame();
    check_frame("d1234", {8'h86, 8'hDB, 8'hCF, 8'hE6});

    // 0050 with dp on digit 2 and leading-zero blanking.
    set_in(16'h0050, 4'b0100, 4'h0, 1'b1);
    cycle(1'b1);
    wait_frame();
    check_frame("d0050", {8'h80, 8'h3F, 8'hED, 8'hBF});

    // All zeros with blanking: only digit 0 remains.
    set_in(16'h0000, 4'h0, 4'h0, 1'b1);
    cycle(1'b1);
    wait_frame();
    check_frame("d0000", {8'h80, 8'h80, 8'h80, 8'hBF});

    // 8888 with digit 0 blinking; the per-cycle model covers the phases.
    set_in(16'h8888, 4'h0, 4'b0001, 1'b0);
    cycle(1'b1);
    repeat (5 * FRAME) cycle(1'b0);

    // Two loads within a frame: last wins, current frame keeps old data.
    set_in(16'h1111, 4'h0, 4'h0, 1'b0);
    while ((t % FRAME) != 5) cycle(1'b0);
    cycle(1'b1);
    repeat (3) cycle(1'b0);
    set_in(16'h2222, 4'h0, 4'h0, 1'b0);
    cycle(1'b1);
    wait_frame();
    check_frame("d2222", {8'hDB, 8'hDB, 8'hDB, 8'hDB});

    // Load exactly on the boundary cycle applies to the frame that starts.
    set_in(16'h5555, 4'h0, 4'h0, 1'b0);
    while (((t + 1) % FRAME) != 0) cycle(1'b0);
    cycle(1'b1);
    checks++;
    assert (frame_done === 1'b1) else begin
      errors++; $error("FAIL bnd_load frame_done got %b exp 1", frame_done);
    end
    check_frame("d5555", {8'hED, 8'hED, 8'hED, 8'hED});

    // Randomized loads against the model.
    for (int i = 0; i < 400; i++) begin
      set_in(16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
      if ($urandom_range(0, 3) == 0) digits_bcd = 16'($urandom_range(0, 9));
      cycle($urandom_range(0, 5) == 0);
    end

    // Asynchronous reset mid-slot.
    while ((t % SD) != 2) cycle(1'b0);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    #4;
    rst_n = 1'b1;
    cycle(1'b0);
    checks++;
    assert (tube_select === 4'b1110) else begin
      errors++; $error("FAIL post_rst sel got %b exp 1110", tube_select);
    end
    checks++;
    assert (tube_value === 8'b1011_1111) else begin
      errors++; $error("FAIL post_rst val got %b exp 10111111", tube_value);
    end
    repeat (2 * FRAME) cycle(1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
